// File: rtl/rv32i_types_pkg.sv
// Shared RV32I types used by the commit side: exception codes and the
// completion-buffer entry layout.
package rv32i_types_pkg;

   typedef enum logic [3:0] {
      EXC_NONE       = 4'd0,
      EXC_FAULT_L    = 4'd1,
      EXC_MAL_L      = 4'd2,
      EXC_FAULT_S    = 4'd3,
      EXC_MAL_S      = 4'd4,
      EXC_MAL_INSN   = 4'd5,
      EXC_FAULT_INSN = 4'd6,
      EXC_ILLEGAL    = 4'd7,
      EXC_BREAKPOINT = 4'd8,
      EXC_ENV_M      = 4'd9,
      EXC_RET        = 4'd10
   } exc_code_t;

   typedef struct packed {
      logic        valid;
      logic        done;
      logic [31:0] pc;
      logic [4:0]  rd;
      logic        wen;
      logic [31:0] data;
      exc_code_t   exc;
      logic [31:0] badaddr;
   } cb_entry_t;

endpackage

// File: rtl/cb_exc_decode.sv
// Decodes an exception code into one-hot trap flags for the hazard unit and
// the commit-side CSR logic.
import rv32i_types_pkg::*;

module cb_exc_decode (
   input  exc_code_t i_exc,
   output logic      o_fault_l,
   output logic      o_mal_l,
   output logic      o_fault_s,
   output logic      o_mal_s,
   output logic      o_mal_insn,
   output logic      o_fault_insn,
   output logic      o_illegal_insn,
   output logic      o_breakpoint,
   output logic      o_env_m,
   output logic      o_ret
);

   // One flag per code; EXC_NONE leaves every flag low.
   always_comb begin
      o_fault_l      = 1'b0;
      o_mal_l        = 1'b0;
      o_fault_s      = 1'b0;
      o_mal_s        = 1'b0;
      o_mal_insn     = 1'b0;
      o_fault_insn   = 1'b0;
      o_illegal_insn = 1'b0;
      o_breakpoint   = 1'b0;
      o_env_m        = 1'b0;
      o_ret          = 1'b0;
      case (i_exc)
         EXC_FAULT_L:    o_fault_l      = 1'b1;
         EXC_MAL_L:      o_mal_l        = 1'b1;
         EXC_FAULT_S:    o_fault_s      = 1'b1;
         EXC_MAL_S:      o_mal_s        = 1'b1;
         EXC_MAL_INSN:   o_mal_insn     = 1'b1;
         EXC_FAULT_INSN: o_fault_insn   = 1'b1;
         EXC_ILLEGAL:    o_illegal_insn = 1'b1;
         EXC_BREAKPOINT: o_breakpoint   = 1'b1;
         EXC_ENV_M:      o_env_m        = 1'b1;
         EXC_RET:        o_ret          = 1'b1;
         default:        ;
      endcase
   end

endmodule

// File: rtl/ooo_completion_buffer.sv
// In-order completion (reorder) buffer. Entries are allocated at dispatch,
// completed out of order by two writeback ports and retired one per cycle
// in program order. Commit/trap outputs are registered from the retiring head.
//
// Allocation handshake: alloc_req is a request, rob_full is the stall.
// An entry is taken on every edge where alloc_req && !rob_full; a request
// while full is dropped, never queued, so decode must hold off on rob_full.
// alloc_tag (the tail index) names the entry taken on that edge.
import rv32i_types_pkg::*;

module ooo_completion_buffer #(
   parameter int DEPTH = 16,
   parameter int TAG_W = $clog2(DEPTH)
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             alloc_req,
   input  logic [31:0]      alloc_pc,
   input  logic [4:0]       alloc_rd,
   input  logic             alloc_wen,
   output logic [TAG_W-1:0] alloc_tag,
   output logic             rob_full,
   output logic             rob_empty,
   input  logic             wb0_valid,
   input  logic [TAG_W-1:0] wb0_tag,
   input  logic [31:0]      wb0_data,
   input  exc_code_t        wb0_exc,
   input  logic             wb1_valid,
   input  logic [TAG_W-1:0] wb1_tag,
   input  logic [31:0]      wb1_data,
   input  exc_code_t        wb1_exc,
   input  logic [31:0]      wb1_badaddr,
   input  logic             flush_req,
   output logic             commit_valid,
   output logic             commit_wen,
   output logic [4:0]       commit_rd,
   output logic [31:0]      commit_data,
   output logic             ex_comm_flush,
   output logic [31:0]      epc,
   output logic [31:0]      badaddr_d,
   output logic             fault_l,
   output logic             mal_l,
   output logic             fault_s,
   output logic             mal_s,
   output logic             mal_insn,
   output logic             fault_insn,
   output logic             illegal_insn,
   output logic             breakpoint,
   output logic             env_m,
   output logic             ret
);

   localparam int CNT_W = TAG_W + 1;

   cb_entry_t        r_entries [DEPTH];
   logic [TAG_W-1:0] r_head;
   logic [TAG_W-1:0] r_tail;
   logic [CNT_W-1:0] r_count;

   logic             r_commit_valid;
   logic             r_commit_wen;
   logic [4:0]       r_commit_rd;
   logic [31:0]      r_commit_data;
   logic             r_ex_flush;
   logic [31:0]      r_epc;
   logic [31:0]      r_badaddr;
   exc_code_t        r_exc_out;

   cb_entry_t        w_head;
   cb_entry_t        w_new;
   logic             w_full;
   logic             w_alloc_ok;
   logic             w_retire;
   logic             w_retire_ok;
   logic             w_retire_exc;

   // Full is judged on the count before this cycle's retire, so a full
   // buffer never accepts in the same cycle it frees a slot.
   assign w_full    = (r_count == CNT_W'(DEPTH));
   assign rob_full  = w_full;
   assign rob_empty = (r_count == '0);
   assign alloc_tag = r_tail;

   // Retire decision from the current head, before this cycle's writebacks land.
   always_comb begin
      w_head       = r_entries[r_head];
      w_alloc_ok   = alloc_req && !w_full;
      w_retire     = w_head.valid && w_head.done && !flush_req;
      w_retire_ok  = w_retire && (w_head.exc == EXC_NONE);
      w_retire_exc = w_retire && (w_head.exc != EXC_NONE);
      w_new        = '0;
      w_new.valid  = 1'b1;
      w_new.pc     = alloc_pc;
      w_new.rd     = alloc_rd;
      w_new.wen    = alloc_wen;
      w_new.exc    = EXC_NONE;
   end

   // Entry array and pointers: flush or a trapping retire empties everything;
   // otherwise allocate at tail, apply writebacks (wb1 last so it wins), retire head.
   always_ff @(posedge CLK) begin
      if (RST || flush_req || w_retire_exc) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_entries[i].valid <= 1'b0;
            r_entries[i].done  <= 1'b0;
         end
      end else begin
         if (w_alloc_ok) begin
            r_entries[r_tail] <= w_new;
            r_tail            <= r_tail + TAG_W'(1);
         end
         if (wb0_valid && r_entries[wb0_tag].valid) begin
            r_entries[wb0_tag].done <= 1'b1;
            r_entries[wb0_tag].data <= wb0_data;
            r_entries[wb0_tag].exc  <= wb0_exc;
         end
         if (wb1_valid && r_entries[wb1_tag].valid) begin
            r_entries[wb1_tag].done    <= 1'b1;
            r_entries[wb1_tag].data    <= wb1_data;
            r_entries[wb1_tag].exc     <= wb1_exc;
            r_entries[wb1_tag].badaddr <= wb1_badaddr;
         end
         if (w_retire_ok) begin
            r_entries[r_head].valid <= 1'b0;
            r_head                  <= r_head + TAG_W'(1);
         end
         case ({w_alloc_ok, w_retire_ok})
            2'b10:   r_count <= r_count + CNT_W'(1);
            2'b01:   r_count <= r_count - CNT_W'(1);
            default: ;
         endcase
      end
   end

   // Registered commit/trap outputs, one cycle after the head retires.
   always_ff @(posedge CLK) begin
      if (RST) begin
         r_commit_valid <= 1'b0;
         r_commit_wen   <= 1'b0;
         r_commit_rd    <= '0;
         r_commit_data  <= '0;
         r_ex_flush     <= 1'b0;
         r_epc          <= '0;
         r_badaddr      <= '0;
         r_exc_out      <= EXC_NONE;
      end else begin
         r_commit_valid <= w_retire_ok;
         r_commit_wen   <= w_retire_ok && w_head.wen && (w_head.rd != 5'd0);
         r_commit_rd    <= w_retire_ok ? w_head.rd : 5'd0;
         r_commit_data  <= w_retire_ok ? w_head.data : 32'd0;
         r_ex_flush     <= w_retire_exc;
         r_epc          <= w_retire_exc ? w_head.pc : 32'd0;
         r_badaddr      <= w_retire_exc ? w_head.badaddr : 32'd0;
         r_exc_out      <= w_retire_exc ? w_head.exc : EXC_NONE;
      end
   end

   assign commit_valid  = r_commit_valid;
   assign commit_wen    = r_commit_wen;
   assign commit_rd     = r_commit_rd;
   assign commit_data   = r_commit_data;
   assign ex_comm_flush = r_ex_flush;
   assign epc           = r_epc;
   assign badaddr_d     = r_badaddr;

   cb_exc_decode u_exc_decode (
      .i_exc          (r_exc_out),
      .o_fault_l      (fault_l),
      .o_mal_l        (mal_l),
      .o_fault_s      (fault_s),
      .o_mal_s        (mal_s),
      .o_mal_insn     (mal_insn),
      .o_fault_insn   (fault_insn),
      .o_illegal_insn (illegal_insn),
      .o_breakpoint   (breakpoint),
      .o_env_m        (env_m),
      .o_ret          (ret)
   );

endmodule

// File: tb/tb_ooo_completion_buffer.sv
// Testbench for ooo_completion_buffer: directed scenarios plus a randomized
// run checked against a program-order queue model of the buffer.
import rv32i_types_pkg::*;

module tb_ooo_completion_buffer;

   localparam int DEPTH = 16;
   localparam int TAG_W = 4;

   logic             CLK = 1'b0;
   logic             RST;
   logic             alloc_req;
   logic [31:0]      alloc_pc;
   logic [4:0]       alloc_rd;
   logic             alloc_wen;
   logic [TAG_W-1:0] alloc_tag;
   logic             rob_full, rob_empty;
   logic             wb0_valid;
   logic [TAG_W-1:0] wb0_tag;
   logic [31:0]      wb0_data;
   exc_code_t        wb0_exc;
   logic             wb1_valid;
   logic [TAG_W-1:0] wb1_tag;
   logic [31:0]      wb1_data;
   exc_code_t        wb1_exc;
   logic [31:0]      wb1_badaddr;
   logic             flush_req;
   logic             commit_valid, commit_wen;
   logic [4:0]       commit_rd;
   logic [31:0]      commit_data;
   logic             ex_comm_flush;
   logic [31:0]      epc, badaddr_d;
   logic             fault_l, mal_l, fault_s, mal_s, mal_insn, fault_insn;
   logic             illegal_insn, breakpoint, env_m, ret;
   logic [9:0]       flags;

   int n_checks = 0;
   int n_fails  = 0;

   // Model entry: one in-flight instruction, kept in program order.
   typedef struct {
      logic [TAG_W-1:0] tag;
      logic [31:0]      pc;
      logic [4:0]       rd;
      logic             wen;
      logic             done;
      logic [31:0]      data;
      exc_code_t        exc;
      logic [31:0]      badaddr;
   } m_ent_t;

   assign flags = {fault_l, mal_l, fault_s, mal_s, mal_insn, fault_insn,
                   illegal_insn, breakpoint, env_m, ret};

   ooo_completion_buffer #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .CLK(CLK), .RST(RST),
      .alloc_req(alloc_req), .alloc_pc(alloc_pc), .alloc_rd(alloc_rd), .alloc_wen(alloc_wen),
      .alloc_tag(alloc_tag), .rob_full(rob_full), .rob_empty(rob_empty),
      .wb0_valid(wb0_valid), .wb0_tag(wb0_tag), .wb0_data(wb0_data), .wb0_exc(wb0_exc),
      .wb1_valid(wb1_valid), .wb1_tag(wb1_tag), .wb1_data(wb1_data), .wb1_exc(wb1_exc),
      .wb1_badaddr(wb1_badaddr), .flush_req(flush_req),
      .commit_valid(commit_valid), .commit_wen(commit_wen), .commit_rd(commit_rd),
      .commit_data(commit_data), .ex_comm_flush(ex_comm_flush), .epc(epc), .badaddr_d(badaddr_d),
      .fault_l(fault_l), .mal_l(mal_l), .fault_s(fault_s), .mal_s(mal_s), .mal_insn(mal_insn),
      .fault_insn(fault_insn), .illegal_insn(illegal_insn), .breakpoint(breakpoint),
      .env_m(env_m), .ret(ret)
   );

   // Clock and watchdog
   always #5 CLK = ~CLK;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Same-tag writeback on both ports in one cycle is illegal stimulus.
   always @(posedge CLK) begin
      if (RST === 1'b0 && wb0_valid && wb1_valid && wb0_tag == wb1_tag) begin
         n_fails++;
         $display("FAIL wb_same_tag: tag %0d on both ports", wb0_tag);
      end
   end

   // Driver tasks
   task automatic idle_inputs();
      alloc_req = 0; alloc_pc = 0; alloc_rd = 0; alloc_wen = 0;
      wb0_valid = 0; wb0_tag = 0; wb0_data = 0; wb0_exc = EXC_NONE;
      wb1_valid = 0; wb1_tag = 0; wb1_data = 0; wb1_exc = EXC_NONE; wb1_badaddr = 0;
      flush_req = 0;
   endtask

   task automatic cycle();
      @(posedge CLK); #1;
   endtask

   task automatic do_reset();
      idle_inputs(); RST = 1; cycle(); RST = 0;
   endtask

   task automatic alloc_one(input logic [31:0] pc, input logic [4:0] rd, input logic wen);
      alloc_req = 1; alloc_pc = pc; alloc_rd = rd; alloc_wen = wen; cycle(); alloc_req = 0;
   endtask

   task automatic test_reset();
      idle_inputs();
      RST = 1; alloc_req = 1; alloc_pc = 32'h40; wb0_valid = 1; flush_req = 0;
      cycle();
      n_checks++;
      if ({commit_valid, commit_wen, commit_rd, commit_data, ex_comm_flush, epc, badaddr_d, flags} !== '0) begin
         n_fails++; $display("FAIL reset_outputs: cv=%b cw=%b rd=%0d data=%h exf=%b epc=%h bad=%h flags=%b",
            commit_valid, commit_wen, commit_rd, commit_data, ex_comm_flush, epc, badaddr_d, flags);
      end
      n_checks++;
      if ({rob_empty, rob_full, alloc_tag} !== {1'b1, 1'b0, 4'd0}) begin
         n_fails++; $display("FAIL reset_status: empty=%b full=%b tag=%0d, want 1 0 0", rob_empty, rob_full, alloc_tag);
      end
      RST = 0; idle_inputs();
   endtask

   task automatic test_ooo_writeback();
      logic [31:0] exp_d [3];
      do_reset();
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if (alloc_tag !== 4'(i)) begin
            n_fails++; $display("FAIL ooo_alloc_tag: got %0d want %0d", alloc_tag, i);
         end
         alloc_one(32'h100 + 32'(4 * i), 5'(i + 1), 1'b1);
      end
      wb0_valid = 1; wb0_tag = 4'd2; wb0_data = 32'hA; cycle();
      n_checks++;
      if (commit_valid !== 1'b0) begin n_fails++; $display("FAIL ooo_early_commit1: cv=%b want 0", commit_valid); end
      wb0_tag = 4'd0; wb0_data = 32'hB; cycle();
      n_checks++;
      if (commit_valid !== 1'b0) begin n_fails++; $display("FAIL ooo_early_commit2: cv=%b want 0", commit_valid); end
      wb0_tag = 4'd1; wb0_data = 32'hC; cycle();
      wb0_valid = 0;
      exp_d[0] = 32'hB; exp_d[1] = 32'hC; exp_d[2] = 32'hA;
      for (int i = 0; i < 3; i++) begin
         n_checks++;
         if ({commit_valid, commit_wen, commit_rd, commit_data} !== {1'b1, 1'b1, 5'(i + 1), exp_d[i]}) begin
            n_fails++; $display("FAIL ooo_commit%0d: cv=%b cw=%b rd=%0d data=%h want 1 1 %0d %h",
               i, commit_valid, commit_wen, commit_rd, commit_data, i + 1, exp_d[i]);
         end
         cycle();
      end
      n_checks++;
      if ({commit_valid, rob_empty} !== 2'b01) begin
         n_fails++; $display("FAIL ooo_drained: cv=%b empty=%b want 0 1", commit_valid, rob_empty);
      end
   endtask

   task automatic test_full_wrap();
      do_reset();
      alloc_req = 1; alloc_wen = 1;
      for (int i = 0; i < DEPTH; i++) begin
         alloc_pc = 32'h1000 + 32'(4 * i); alloc_rd = 5'(i + 1); cycle();
      end
      n_checks++;
      if ({rob_full, rob_empty, alloc_tag} !== {1'b1, 1'b0, 4'd0}) begin
         n_fails++; $display("FAIL full_status: full=%b empty=%b tag=%0d want 1 0 0", rob_full, rob_empty, alloc_tag);
      end
      alloc_pc = 32'h999; alloc_rd = 5'd20; cycle();
      n_checks++;
      if ({rob_full, alloc_tag} !== {1'b1, 4'd0}) begin
         n_fails++; $display("FAIL full_drop17: full=%b tag=%0d want 1 0", rob_full, alloc_tag);
      end
      wb0_valid = 1; wb0_tag = 4'd0; wb0_data = 32'h100; cycle(); wb0_valid = 0;
      n_checks++;
      if ({rob_full, commit_valid} !== 2'b10) begin
         n_fails++; $display("FAIL full_head_done: full=%b cv=%b want 1 0", rob_full, commit_valid);
      end
      cycle();
      n_checks++;
      if ({commit_valid, commit_rd, commit_data, rob_full, alloc_tag} !== {1'b1, 5'd1, 32'h100, 1'b0, 4'd0}) begin
         n_fails++; $display("FAIL full_retire: cv=%b rd=%0d data=%h full=%b tag=%0d want 1 1 100 0 0",
            commit_valid, commit_rd, commit_data, rob_full, alloc_tag);
      end
      cycle();
      alloc_req = 0;
      n_checks++;
      if ({rob_full, alloc_tag, commit_valid} !== {1'b1, 4'd1, 1'b0}) begin
         n_fails++; $display("FAIL full_realloc: full=%b tag=%0d cv=%b want 1 1 0", rob_full, alloc_tag, commit_valid);
      end
      for (int k = 1; k <= DEPTH; k++) begin
         wb0_valid = 1; wb0_tag = 4'(k);
         wb0_data = (k == DEPTH) ? 32'h77 : 32'h100 + 32'(k);
         cycle();
         n_checks++;
         if (k < 2) begin
            if (commit_valid !== 1'b0) begin n_fails++; $display("FAIL wrap_commit_k1: cv=%b want 0", commit_valid); end
         end else if ({commit_valid, commit_rd, commit_data} !== {1'b1, 5'(k), 32'h100 + 32'(k - 1)}) begin
            n_fails++; $display("FAIL wrap_commit_k%0d: cv=%b rd=%0d data=%h want 1 %0d %h",
               k, commit_valid, commit_rd, commit_data, k, 32'h100 + 32'(k - 1));
         end
      end
      wb0_valid = 0; cycle();
      n_checks++;
      if ({commit_valid, commit_rd, commit_data} !== {1'b1, 5'd20, 32'h77}) begin
         n_fails++; $display("FAIL wrap_tag0_commit: cv=%b rd=%0d data=%h want 1 20 77", commit_valid, commit_rd, commit_data);
      end
      cycle();
      n_checks++;
      if ({commit_valid, rob_empty} !== 2'b01) begin
         n_fails++; $display("FAIL wrap_drained: cv=%b empty=%b want 0 1", commit_valid, rob_empty);
      end
   endtask

   task automatic test_exception();
      do_reset();
      for (int i = 0; i < 3; i++) alloc_one(32'h200 + 32'(4 * i), 5'(i + 4), 1'b1);
      wb0_valid = 1; wb0_tag = 4'd0; wb0_data = 32'h11;
      wb1_valid = 1; wb1_tag = 4'd1; wb1_data = 32'h0; wb1_exc = EXC_FAULT_L; wb1_badaddr = 32'hDEAD0000;
      cycle();
      wb1_valid = 0; wb1_exc = EXC_NONE;
      wb0_tag = 4'd2; wb0_data = 32'h22; cycle(); wb0_valid = 0;
      n_checks++;
      if ({commit_valid, commit_rd, commit_data, ex_comm_flush} !== {1'b1, 5'd4, 32'h11, 1'b0}) begin
         n_fails++; $display("FAIL exc_prior_commit: cv=%b rd=%0d data=%h exf=%b want 1 4 11 0",
            commit_valid, commit_rd, commit_data, ex_comm_flush);
      end
      cycle();
      n_checks++;
      if ({ex_comm_flush, commit_valid, epc, badaddr_d, flags} !== {1'b1, 1'b0, 32'h204, 32'hDEAD0000, 10'b10_0000_0000}) begin
         n_fails++; $display("FAIL exc_trap: exf=%b cv=%b epc=%h bad=%h flags=%b want 1 0 204 dead0000 1000000000",
            ex_comm_flush, commit_valid, epc, badaddr_d, flags);
      end
      n_checks++;
      if ({rob_empty, alloc_tag} !== {1'b1, 4'd0}) begin
         n_fails++; $display("FAIL exc_cleared: empty=%b tag=%0d want 1 0", rob_empty, alloc_tag);
      end
      cycle();
      n_checks++;
      if ({commit_valid, ex_comm_flush} !== 2'b00) begin
         n_fails++; $display("FAIL exc_no_entry2: cv=%b exf=%b want 0 0", commit_valid, ex_comm_flush);
      end
   endtask

   task automatic test_rd_zero();
      do_reset();
      alloc_one(32'h300, 5'd0, 1'b1);
      alloc_one(32'h304, 5'd7, 1'b0);
      wb0_valid = 1; wb0_tag = 4'd0; wb0_data = 32'h5;
      wb1_valid = 1; wb1_tag = 4'd1; wb1_data = 32'h6;
      cycle(); wb0_valid = 0; wb1_valid = 0;
      cycle();
      n_checks++;
      if ({commit_valid, commit_wen, commit_rd, commit_data} !== {1'b1, 1'b0, 5'd0, 32'h5}) begin
         n_fails++; $display("FAIL rd0_commit: cv=%b cw=%b rd=%0d data=%h want 1 0 0 5", commit_valid, commit_wen, commit_rd, commit_data);
      end
      cycle();
      n_checks++;
      if ({commit_valid, commit_wen, commit_rd, commit_data} !== {1'b1, 1'b0, 5'd7, 32'h6}) begin
         n_fails++; $display("FAIL nowen_commit: cv=%b cw=%b rd=%0d data=%h want 1 0 7 6", commit_valid, commit_wen, commit_rd, commit_data);
      end
   endtask

   task automatic test_flush_priority();
      do_reset();
      alloc_one(32'h400, 5'd1, 1'b1);
      alloc_one(32'h404, 5'd2, 1'b1);
      wb0_valid = 1; wb0_tag = 4'd0; wb0_exc = EXC_ILLEGAL; cycle();
      wb0_valid = 0; wb0_exc = EXC_NONE;
      flush_req = 1; alloc_req = 1; alloc_pc = 32'h500; alloc_rd = 5'd3; alloc_wen = 1;
      cycle();
      flush_req = 0; alloc_req = 0;
      n_checks++;
      if ({ex_comm_flush, commit_valid, rob_empty, rob_full, alloc_tag, illegal_insn} !== {1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0}) begin
         n_fails++; $display("FAIL flush_prio: exf=%b cv=%b empty=%b full=%b tag=%0d ill=%b want 0 0 1 0 0 0",
            ex_comm_flush, commit_valid, rob_empty, rob_full, alloc_tag, illegal_insn);
      end
      cycle();
      n_checks++;
      if ({ex_comm_flush, commit_valid} !== 2'b00) begin
         n_fails++; $display("FAIL flush_after: exf=%b cv=%b want 0 0", ex_comm_flush, commit_valid);
      end
   endtask

   task automatic test_mid_reset();
      do_reset();
      for (int i = 0; i < 5; i++) alloc_one(32'h600 + 32'(4 * i), 5'(i + 1), 1'b1);
      wb0_valid = 1; wb0_tag = 4'd1; wb0_data = 32'h61; cycle();
      RST = 1; wb0_tag = 4'd0; wb0_data = 32'h60; alloc_req = 1; alloc_pc = 32'h700;
      cycle();
      RST = 0; idle_inputs();
      n_checks++;
      if ({commit_valid, commit_wen, commit_rd, commit_data, ex_comm_flush, epc, badaddr_d, flags,
           rob_full, alloc_tag} !== '0 || rob_empty !== 1'b1) begin
         n_fails++; $display("FAIL midrst_outputs: cv=%b exf=%b full=%b empty=%b tag=%0d",
            commit_valid, ex_comm_flush, rob_full, rob_empty, alloc_tag);
      end
      wb0_valid = 1; wb0_tag = 4'd3; wb0_data = 32'h33; cycle(); wb0_valid = 0;
      for (int i = 0; i < 3; i++) begin
         cycle();
         n_checks++;
         if ({commit_valid, ex_comm_flush, rob_empty} !== 3'b001) begin
            n_fails++; $display("FAIL midrst_late_wb%0d: cv=%b exf=%b empty=%b want 0 0 1", i, commit_valid, ex_comm_flush, rob_empty);
         end
      end
   endtask

   task automatic test_random();
      m_ent_t           q[$];
      m_ent_t           e;
      logic [TAG_W-1:0] mtail;
      logic             full_before;
      logic             exp_cv, exp_cwen, exp_ex;
      logic [4:0]       exp_rd;
      logic [31:0]      exp_data, exp_epc, exp_bad;
      logic [9:0]       exp_flags;
      do_reset();
      mtail = '0;
      for (int c = 0; c < 3000; c++) begin
         n_checks++;
         if ({rob_full, rob_empty, alloc_tag} !== {q.size() == DEPTH, q.size() == 0, mtail}) begin
            n_fails++; $display("FAIL rnd_status c%0d: full=%b empty=%b tag=%0d want %b %b %0d",
               c, rob_full, rob_empty, alloc_tag, q.size() == DEPTH, q.size() == 0, mtail);
         end
         alloc_req   = ($urandom_range(0, 99) < 60);
         alloc_pc    = $urandom;
         alloc_rd    = 5'($urandom_range(0, 31));
         alloc_wen   = 1'($urandom_range(0, 1));
         wb0_valid   = ($urandom_range(0, 99) < 50);
         wb0_tag     = 4'($urandom_range(0, DEPTH - 1));
         wb0_data    = $urandom;
         wb0_exc     = ($urandom_range(0, 99) == 0) ? exc_code_t'(4'($urandom_range(7, 10))) : EXC_NONE;
         wb1_valid   = ($urandom_range(0, 99) < 50);
         wb1_tag     = 4'($urandom_range(0, DEPTH - 1));
         if (wb1_tag == wb0_tag) wb1_tag = wb0_tag + 4'd1;
         wb1_data    = $urandom;
         wb1_exc     = ($urandom_range(0, 99) == 0) ? exc_code_t'(4'($urandom_range(1, 10))) : EXC_NONE;
         wb1_badaddr = $urandom;
         flush_req   = ($urandom_range(0, 199) == 0);

         // Reference model: oldest done entry leaves; trap or flush empties all.
         full_before = (q.size() == DEPTH);
         exp_cv = 0; exp_cwen = 0; exp_ex = 0; exp_rd = 0; exp_data = 0;
         exp_epc = 0; exp_bad = 0; exp_flags = 0;
         if (!flush_req && q.size() > 0 && q[0].done) begin
            if (q[0].exc == EXC_NONE) begin
               exp_cv = 1; exp_cwen = q[0].wen && (q[0].rd != 0); exp_rd = q[0].rd; exp_data = q[0].data;
            end else begin
               exp_ex = 1; exp_epc = q[0].pc; exp_bad = q[0].badaddr;
               exp_flags = 10'b1 << (10 - int'(q[0].exc));
            end
            void'(q.pop_front());
         end
         foreach (q[i]) begin
            if (wb0_valid && q[i].tag == wb0_tag) begin
               q[i].done = 1; q[i].data = wb0_data; q[i].exc = wb0_exc;
            end
            if (wb1_valid && q[i].tag == wb1_tag) begin
               q[i].done = 1; q[i].data = wb1_data; q[i].exc = wb1_exc; q[i].badaddr = wb1_badaddr;
            end
         end
         if (alloc_req && !full_before) begin
            e.tag = mtail; e.pc = alloc_pc; e.rd = alloc_rd; e.wen = alloc_wen;
            e.done = 0; e.data = 0; e.exc = EXC_NONE; e.badaddr = 0;
            q.push_back(e);
            mtail = mtail + 4'd1;
         end
         if (flush_req || exp_ex) begin
            q.delete(); mtail = '0;
         end

         cycle();
         n_checks++;
         if ({commit_valid, ex_comm_flush} !== {exp_cv, exp_ex}) begin
            n_fails++; $display("FAIL rnd_retire c%0d: cv=%b exf=%b want %b %b", c, commit_valid, ex_comm_flush, exp_cv, exp_ex);
         end
         if (exp_cv) begin
            n_checks++;
            if ({commit_wen, commit_rd, commit_data} !== {exp_cwen, exp_rd, exp_data}) begin
               n_fails++; $display("FAIL rnd_commit c%0d: cw=%b rd=%0d data=%h want %b %0d %h",
                  c, commit_wen, commit_rd, commit_data, exp_cwen, exp_rd, exp_data);
            end
         end
         if (exp_ex) begin
            n_checks++;
            if ({epc, badaddr_d, flags} !== {exp_epc, exp_bad, exp_flags}) begin
               n_fails++; $display("FAIL rnd_trap c%0d: epc=%h bad=%h flags=%b want %h %h %b",
                  c, epc, badaddr_d, flags, exp_epc, exp_bad, exp_flags);
            end
         end
      end
      idle_inputs();
   endtask

   // Test sequence and final report
   initial begin
      idle_inputs();
      RST = 1;
      cycle();
      test_reset();
      test_ooo_writeback();
      test_full_wrap();
      test_exception();
      test_rd_zero();
      test_flush_priority();
      test_mid_reset();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
      $finish;
   end

endmodule

// File: doc/ooo_completion_buffer.md
Name: ooo_completion_buffer

Overview:
- In-order completion (reorder) buffer between the out-of-order execute units and the architectural register file.
- Allocates one entry per dispatched instruction and records writebacks from the execute units in any order.
- Retires at most one instruction per cycle, in program order.
- Drives the hazard unit's commit-side signals: rob_full, exception flags, epc, badaddr, ex_comm_flush.

Parameters:
DEPTH, 16, number of entries; power of two, at least 4.
TAG_W, $clog2(DEPTH), width of entry tag/index.

Ports:
CLK  in  1  clock
RST  in  1  synchronous active-high reset
alloc_req  in  1  decode requests an entry this cycle
alloc_pc  in  32  PC of the dispatched instruction
alloc_rd  in  5  destination register
alloc_wen  in  1  instruction writes rd
alloc_tag  out  TAG_W  tag for the current allocation (tail index)
rob_full  out  1  no free entry; combinational from count
rob_empty  out  1  count == 0
wb0_valid  in  1  arithmetic/mul/div writeback
wb0_tag  in  TAG_W  entry being completed
wb0_data  in  32  result
wb0_exc  in  4  exc_code_t; ILLEGAL/BREAKPOINT/ENV_M/RET only
wb1_valid  in  1  load/store writeback
wb1_tag  in  TAG_W  entry being completed
wb1_data  in  32  load data
wb1_exc  in  4  exc_code_t
wb1_badaddr  in  32  faulting data address
flush_req  in  1  external flush from the hazard unit (e.g. mispredict)
commit_valid  out  1  head retired this cycle with no exception
commit_wen  out  1  commit_valid && entry.wen && rd != 0
commit_rd  out  5  destination register
commit_data  out  32  result
ex_comm_flush  out  1  head retired with an exception; one-cycle pulse
epc  out  32  PC of the excepting instruction
badaddr_d  out  32  data fault address
fault_l, mal_l, fault_s, mal_s, mal_insn, fault_insn, illegal_insn, breakpoint, env_m, ret  out  1 each  decoded from the head's exc code; valid only with ex_comm_flush

Behaviour:
- Reset (RST high at a CLK edge): head = tail = count = 0; all entry valid/done bits cleared. Every output is 0 except rob_empty = 1 and alloc_tag = 0. Reset overrides all other inputs.
- Entry fields: valid, done, pc, rd, wen, data, exc, badaddr.
- Allocation:
  - Accepted when alloc_req && !rob_full.
  - Writes pc, rd and wen into entry[tail]; sets valid = 1, done = 0, exc = NONE; tail increments modulo DEPTH.
  - alloc_tag always equals tail.
  - A request while full is dropped; decode must stall on rob_full.
- Writeback:
  - A wbN_valid whose target entry has valid = 1 sets done = 1 and stores data, exc and (wb1 only) badaddr.
  - A writeback to an entry with valid = 0 is ignored.
  - wb0 and wb1 hitting the same tag in the same cycle is illegal; the bench asserts on it, and wb1 wins.
- Retire (combinational from the head, registered outputs one cycle later):
  - Retire occurs when entry[head] has valid && done. It clears valid and increments head modulo DEPTH.
  - exc == NONE: next cycle commit_valid = 1 with rd, data and wen; commit_wen is suppressed for rd = 0.
  - exc != NONE: next cycle ex_comm_flush = 1, epc = pc, the matching flag = 1, badaddr_d = badaddr; commit_valid = 0.
  - The same edge that registers the exception clears the whole buffer: head = tail = count = 0, all valid = 0.
- Latency: writeback to commit output is at least 1 cycle. A back-to-back stream retires 1 per cycle.
- count update:
  - +1 on accepted alloc, -1 on retire; simultaneous alloc and retire leaves count unchanged.
  - rob_full = (count == DEPTH) and is evaluated before this cycle's retire, so a full buffer never accepts in the retire cycle.
- Wrap-around: head and tail are TAG_W bits wide and wrap naturally; full versus empty is distinguished only by count (TAG_W+1 bits).
- flush_req:
  - Clears all entries, head, tail and count at the next edge.
  - Same-cycle alloc, writeback and retire are discarded, so commit_valid and ex_comm_flush are 0 next cycle.
  - flush_req has priority over an exception retire in the same cycle.
- Mid-operation RST behaves exactly like power-on reset.

Decomposition:
- rv32i_types_pkg gains:
  - exc_code_t (4-bit enum: NONE, FAULT_L, MAL_L, FAULT_S, MAL_S, MAL_INSN, FAULT_INSN, ILLEGAL, BREAKPOINT, ENV_M, RET)
  - cb_entry_t (packed struct of the entry fields)
- One sub-module, cb_exc_decode: combinational decode of exc_code_t into the ten one-hot flags. It is reused later by the commit-side CSR logic.

Test Plan:
- Reset then allocate 3 entries (PC 0x100/0x104/0x108, rd 1/2/3) → alloc_tag 0, 1, 2; writeback in order tag 2, 0, 1 with data 0xA/0xB/0xC → commit of rd 1 = 0xB, then rd 2 = 0xC, then rd 3 = 0xA, on consecutive cycles in program order.
- Fill DEPTH = 16 entries → rob_full = 1; 17th alloc_req dropped; complete and retire the head while alloc_req is held → new entry accepted the cycle after retire; tail wraps to 0, and a subsequent alloc gets tag 0 correctly.
- Entry 1 of 3 completes on wb1 with exc = FAULT_L, badaddr 0xDEAD0000, PC 0x204 → entry 0 commits normally; next cycle ex_comm_flush = 1, fault_l = 1, epc = 0x204, badaddr_d = 0xDEAD0000; then rob_empty = 1, entry 2 never commits.
- Entry with rd = 0, wen = 1 completes → commit_valid = 1, commit_wen = 0.
- flush_req asserted in the same cycle as head completion with exc = ILLEGAL and an alloc_req → next cycle ex_comm_flush = 0, commit_valid = 0, count = 0, alloc_tag = 0.
- RST asserted with 5 entries pending → all outputs at reset values next cycle; a late wb0 to the old tag 3 is ignored, and no commit follows.
